// File: rtl/shift_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : shift_arb_pkg
//  Description : Shared widths, defaults and FSM state type for shift_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package shift_arb_pkg;

    localparam int DATA_W          = 32;
    localparam int SHAMT_W         = 5;
    localparam int CTRL_W          = 5;
    localparam int CNT_W           = 8;
    localparam int TIMEOUT_DEFAULT = 40;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/shift_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : shift_arbiter_if
//  Description : Requester, shifter and response signals of shift_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface shift_arbiter_if;
    import shift_arb_pkg::*;

    logic               req0_valid;
    logic               req0_ready;
    logic [DATA_W-1:0]  req0_a;
    logic [SHAMT_W-1:0] req0_b;
    logic [CTRL_W-1:0]  req0_ctrl;

    logic               req1_valid;
    logic               req1_ready;
    logic [DATA_W-1:0]  req1_a;
    logic [SHAMT_W-1:0] req1_b;
    logic [CTRL_W-1:0]  req1_ctrl;

    logic               sh_start;
    logic [DATA_W-1:0]  sh_a;
    logic [SHAMT_W-1:0] sh_b;
    logic [CTRL_W-1:0]  sh_ctrl;
    logic               sh_done;
    logic [DATA_W-1:0]  sh_result;

    logic               resp_valid;
    logic               resp_ready;
    logic               resp_id;
    logic [DATA_W-1:0]  resp_data;
    logic               resp_err;

    // The arbiter itself
    modport slave (
        input  req0_valid, req0_a, req0_b, req0_ctrl,
        input  req1_valid, req1_a, req1_b, req1_ctrl,
        input  sh_done, sh_result, resp_ready,
        output req0_ready, req1_ready,
        output sh_start, sh_a, sh_b, sh_ctrl,
        output resp_valid, resp_id, resp_data, resp_err
    );

    // Requesters, shifter and response consumer seen together
    modport master (
        output req0_valid, req0_a, req0_b, req0_ctrl,
        output req1_valid, req1_a, req1_b, req1_ctrl,
        output sh_done, sh_result, resp_ready,
        input  req0_ready, req1_ready,
        input  sh_start, sh_a, sh_b, sh_ctrl,
        input  resp_valid, resp_id, resp_data, resp_err
    );

endinterface
`default_nettype wire

// File: rtl/shift_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Two-input round-robin grant; pointer moves on accept only.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    input  logic       i_accept,
    output logic [1:0] o_grant
);

    // 0 favours requester 0, 1 favours requester 1
    logic r_ptr;

    always_comb begin
        o_grant = 2'b00;
        if (r_ptr == 1'b0) begin
            if (i_req[0])      o_grant = 2'b01;
            else if (i_req[1]) o_grant = 2'b10;
        end else begin
            if (i_req[1])      o_grant = 2'b10;
            else if (i_req[0]) o_grant = 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= 1'b0;
        end else if (i_accept) begin
            r_ptr <= ~o_grant[1];
        end
    end

endmodule
`default_nettype wire

// File: rtl/shift_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : shift_arbiter
//  Description : Shares one iterative shifter between two requesters with
//                round-robin grant, bypass for zero shifts and a watchdog.
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_arbiter
    import shift_arb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic           clk,
    input  logic           rst_n,
    shift_arbiter_if.slave bus
);

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [DATA_W-1:0]  r_a;
    logic [SHAMT_W-1:0] r_b;
    logic [CTRL_W-1:0]  r_ctrl;
    logic               r_id;
    logic [DATA_W-1:0]  r_resp_data;
    logic               r_resp_err;

    logic               w_idle;
    logic [1:0]         w_req;
    logic [1:0]         w_grant;
    logic               w_accept;
    logic               w_gid;
    logic [DATA_W-1:0]  w_a;
    logic [SHAMT_W-1:0] w_b;
    logic [CTRL_W-1:0]  w_ctrl;
    logic               w_timeout;
    logic               w_sh_start;
    logic               w_resp_valid;

    // Ready must read 0 while reset is held even though the state is IDLE
    assign w_idle = (r_state == IDLE) && rst_n;
    assign w_req  = {bus.req1_valid, bus.req0_valid} & {2{w_idle}};

    rr_arb2 u_rr_arb2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_req    (w_req),
        .i_accept (w_accept),
        .o_grant  (w_grant)
    );

    assign w_accept  = |w_grant;
    assign w_gid     = w_grant[1];
    assign w_a       = w_gid ? bus.req1_a    : bus.req0_a;
    assign w_b       = w_gid ? bus.req1_b    : bus.req0_b;
    assign w_ctrl    = w_gid ? bus.req1_ctrl : bus.req0_ctrl;
    assign w_timeout = (r_cnt == c_CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_sh_start   = 1'b0;
        w_resp_valid = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (w_b == '0) ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                w_sh_start  = 1'b1;
                w_state_nxt = WAIT;
            end
            WAIT: begin
                if (bus.sh_done || w_timeout) begin
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                w_resp_valid = 1'b1;
                if (bus.resp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_ctrl      <= '0;
            r_id        <= 1'b0;
            r_resp_data <= '0;
            r_resp_err  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a    <= w_a;
                        r_b    <= w_b;
                        r_ctrl <= w_ctrl;
                        r_id   <= w_gid;
                        if (w_b == '0) begin
                            r_resp_data <= w_a;
                            r_resp_err  <= 1'b0;
                        end
                    end
                end
                ISSUE: begin
                    r_cnt <= '0;
                end
                WAIT: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    // A done on the last watchdog cycle still delivers data
                    if (bus.sh_done) begin
                        r_resp_data <= bus.sh_result;
                        r_resp_err  <= 1'b0;
                    end else if (w_timeout) begin
                        r_resp_data <= '0;
                        r_resp_err  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req0_ready = w_grant[0];
    assign bus.req1_ready = w_grant[1];
    assign bus.sh_start   = w_sh_start;
    assign bus.sh_a       = r_a;
    assign bus.sh_b       = r_b;
    assign bus.sh_ctrl    = r_ctrl;
    assign bus.resp_valid = w_resp_valid;
    assign bus.resp_id    = r_id;
    assign bus.resp_data  = r_resp_data;
    assign bus.resp_err   = r_resp_err;

endmodule
`default_nettype wire

// File: tb/tb_shift_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_arbiter
//  Description : Self-checking bench for shift_arbiter with a shifter model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_arbiter;

    localparam int TIMEOUT = 16;

    localparam logic [4:0] SLL = 5'd0;
    localparam logic [4:0] SRL = 5'd1;
    localparam logic [4:0] SRA = 5'd2;
    localparam logic [4:0] ROL = 5'd3;

    typedef struct {
        logic        v0;
        logic        v1;
        logic [31:0] a0;
        logic [4:0]  b0;
        logic [4:0]  c0;
        logic [31:0] a1;
        logic [4:0]  b1;
        logic [4:0]  c1;
        int          lat;   // shifter latency, -1 = never done
        int          hold;  // extra cycles resp_ready stays low
        int          id;
        logic [31:0] data;
        logic        err;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        shf_done;
    logic        spur_done;
    logic [31:0] shf_result;
    int          shf_lat;
    int          rr_last;
    int          n_checks;
    int          n_fail;
    vec_t        vecs[13];

    shift_arbiter_if bus ();

    assign bus.sh_done   = shf_done | spur_done;
    assign bus.sh_result = shf_result;

    shift_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_shift(input logic [31:0] a,
                                              input logic [4:0] b,
                                              input logic [4:0] c);
        case (c)
            SLL:     return a << b;
            SRL:     return a >> b;
            SRA:     return $unsigned($signed(a) >>> b);
            default: return (a << b) | (a >> (32 - int'(b)));
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Shifter model: answers a start after shf_lat cycles using the operands
    // the arbiter is still presenting at that time.
    initial begin
        int l;
        shf_done   = 1'b0;
        shf_result = 32'h0;
        forever begin
            @(negedge clk);
            if (bus.sh_start && shf_lat > 0) begin
                l = shf_lat;
                repeat (l) @(posedge clk);
                #1;
                shf_done   = 1'b1;
                shf_result = ref_shift(bus.sh_a, bus.sh_b, bus.sh_ctrl);
                @(posedge clk);
                #1;
                shf_done   = 1'b0;
                shf_result = $urandom;
            end
        end
    end

    // Called at posedge+1 with the arbiter idle; returns at posedge+1 after
    // the response handshake.
    task automatic do_op(input vec_t v);
        logic [4:0] wb;
        int         exp_k;
        wb = (v.id == 1) ? v.b1 : v.b0;
        if (wb == 5'd0)                     exp_k = 1;
        else if (v.lat >= 1 && v.lat <= TIMEOUT) exp_k = 2 + v.lat;
        else                                exp_k = 2 + TIMEOUT;
        shf_lat       = v.lat;
        bus.req0_valid = v.v0;
        bus.req0_a     = v.a0;
        bus.req0_b     = v.b0;
        bus.req0_ctrl  = v.c0;
        bus.req1_valid = v.v1;
        bus.req1_a     = v.a1;
        bus.req1_b     = v.b1;
        bus.req1_ctrl  = v.c1;
        @(negedge clk);
        chk("ready0_grant", bus.req0_ready, v.id == 0);
        chk("ready1_grant", bus.req1_ready, v.id == 1);
        chk("resp_valid_idle", bus.resp_valid, 0);
        @(posedge clk);
        #1;
        for (int k = 1; k <= exp_k + v.hold; k++) begin
            if (k == exp_k + v.hold) bus.resp_ready = 1'b1;
            @(negedge clk);
            chk("sh_start", bus.sh_start, (wb != 5'd0) && (k == 1));
            chk("ready0_busy", bus.req0_ready, 0);
            chk("ready1_busy", bus.req1_ready, 0);
            chk("resp_valid", bus.resp_valid, k >= exp_k);
            if (k >= exp_k) begin
                chk("resp_id", bus.resp_id, v.id);
                chk("resp_data", bus.resp_data, v.data);
                chk("resp_err", bus.resp_err, v.err);
            end
            @(posedge clk);
            #1;
        end
        bus.resp_ready = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        rr_last        = v.id;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got time %0t expected < 500000", $time);
        $fatal(1);
    end

    initial begin
        vec_t        r;
        int          sel;
        int          win;
        logic [31:0] wa;
        logic [4:0]  wb;
        logic [4:0]  wc;

        n_checks       = 0;
        n_fail         = 0;
        rst_n          = 1'b0;
        spur_done      = 1'b0;
        shf_lat        = -1;
        rr_last        = 1;
        bus.req0_valid = 1'b0;
        bus.req0_a     = '0;
        bus.req0_b     = '0;
        bus.req0_ctrl  = '0;
        bus.req1_valid = 1'b0;
        bus.req1_a     = '0;
        bus.req1_b     = '0;
        bus.req1_ctrl  = '0;
        bus.resp_ready = 1'b0;

        //          v0 v1 a0            b0     c0   a1            b1     c1   lat          hold id data          err
        vecs[0]  = '{1, 1, 32'h1,        5'd1,  SLL, 32'h80,       5'd3,  SRL, 2,           0,   0, 32'h2,        0};
        vecs[1]  = '{1, 1, 32'h1,        5'd1,  SLL, 32'h80,       5'd3,  SRL, 2,           0,   1, 32'h10,       0};
        vecs[2]  = '{1, 1, 32'h3,        5'd1,  SLL, 32'hF0,       5'd4,  SRL, 3,           1,   0, 32'h6,        0};
        vecs[3]  = '{1, 1, 32'h3,        5'd1,  SLL, 32'hF0,       5'd4,  SRL, 3,           1,   1, 32'hF,        0};
        vecs[4]  = '{1, 0, 32'hF1,       5'd4,  SLL, 32'h0,        5'd0,  SLL, 5,           0,   0, 32'hF10,      0};
        vecs[5]  = '{0, 1, 32'h0,        5'd0,  SLL, 32'hDEADBEEF, 5'd0,  SLL, 3,           0,   1, 32'hDEADBEEF, 0};
        vecs[6]  = '{1, 0, 32'h12345678, 5'd8,  SLL, 32'h0,        5'd0,  SLL, -1,          2,   0, 32'h0,        1};
        vecs[7]  = '{0, 1, 32'h0,        5'd0,  SLL, 32'h80000000, 5'd4,  SRA, TIMEOUT,     0,   1, 32'hF8000000, 0};
        vecs[8]  = '{1, 1, 32'hA5,       5'd2,  ROL, 32'h5,        5'd1,  SLL, 3,           10,  0, 32'h294,      0};
        vecs[9]  = '{0, 1, 32'h0,        5'd0,  SLL, 32'hFFFF0000, 5'd31, SRL, 1,           0,   1, 32'h1,        0};
        vecs[10] = '{1, 0, 32'h7,        5'd1,  SLL, 32'h0,        5'd0,  SLL, TIMEOUT - 1, 0,   0, 32'hE,        0};
        vecs[11] = '{1, 0, 32'hF,        5'd3,  SLL, 32'h0,        5'd0,  SLL, TIMEOUT + 1, 0,   0, 32'h0,        1};
        vecs[12] = '{1, 1, 32'h21,       5'd2,  SRL, 32'h44,       5'd1,  SLL, 4,           0,   0, 32'h8,        0};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_sh_start", bus.sh_start, 0);
        chk("rst_resp_data", bus.resp_data, 0);
        chk("rst_resp_err", bus.resp_err, 0);
        chk("rst_resp_id", bus.resp_id, 0);
        chk("rst_sh_a", bus.sh_a, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) do_op(vecs[i]);

        // sh_done while idle must not produce a response
        spur_done = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("spur_resp_valid", bus.resp_valid, 0);
            chk("spur_sh_start", bus.sh_start, 0);
            @(posedge clk);
            #1;
        end
        spur_done = 1'b0;

        // Reset in the middle of WAIT drops the operation
        shf_lat        = -1;
        bus.req0_valid = 1'b1;
        bus.req0_a     = 32'h55;
        bus.req0_b     = 5'd3;
        bus.req0_ctrl  = SLL;
        @(posedge clk);
        #1;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_sh_a", bus.sh_a, 32'h55);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_sh_a", bus.sh_a, 0);
        chk("mid_rst_sh_b", bus.sh_b, 0);
        chk("mid_rst_sh_ctrl", bus.sh_ctrl, 0);
        chk("mid_rst_sh_start", bus.sh_start, 0);
        chk("mid_rst_ready0", bus.req0_ready, 0);
        chk("mid_rst_ready1", bus.req1_ready, 0);
        chk("mid_rst_resp_valid", bus.resp_valid, 0);
        chk("mid_rst_resp_data", bus.resp_data, 0);
        chk("mid_rst_resp_err", bus.resp_err, 0);
        chk("mid_rst_resp_id", bus.resp_id, 0);
        @(posedge clk);
        #1;
        bus.req0_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        rr_last = 1;
        do_op(vecs[12]);

        // Randomised traffic against the round-robin reference
        for (int i = 0; i < 60; i++) begin
            sel  = int'($urandom_range(1, 3));
            r.v0 = (sel != 2);
            r.v1 = (sel != 1);
            r.a0 = $urandom;
            r.a1 = $urandom;
            r.b0 = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            r.b1 = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            r.c0 = 5'($urandom_range(0, 3));
            r.c1 = 5'($urandom_range(0, 3));
            r.lat  = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(1, TIMEOUT + 1));
            r.hold = int'($urandom_range(0, 3));
            if (r.v0 && r.v1) win = (rr_last == 0) ? 1 : 0;
            else              win = r.v0 ? 0 : 1;
            wa = (win == 1) ? r.a1 : r.a0;
            wb = (win == 1) ? r.b1 : r.b0;
            wc = (win == 1) ? r.c1 : r.c0;
            r.id = win;
            if (wb == 5'd0) begin
                r.data = wa;
                r.err  = 1'b0;
            end else if (r.lat >= 1 && r.lat <= TIMEOUT) begin
                r.data = ref_shift(wa, wb, wc);
                r.err  = 1'b0;
            end else begin
                r.data = 32'h0;
                r.err  = 1'b1;
            end
            do_op(r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
